// File: rtl/instruction_dump_pkg.sv
// Shared definitions for the instruction loader/dump pair: state encoding and
// the 6/6/4 chunk packing of a 16-bit instruction word.
package instruction_dump_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      SHOW0 = 3'd3,
      SHOW1 = 3'd4,
      SHOW2 = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam int CHUNK0_MSB = 15;
   localparam int CHUNK0_LSB = 10;
   localparam int CHUNK1_MSB = 9;
   localparam int CHUNK1_LSB = 4;
   localparam int CHUNK2_MSB = 3;
   localparam int CHUNK2_LSB = 0;

   localparam logic [1:0] CHUNK_IDX0 = 2'd0;
   localparam logic [1:0] CHUNK_IDX1 = 2'd1;
   localparam logic [1:0] CHUNK_IDX2 = 2'd2;

   // Zero-extended chunk as shown on the LEDs, same slicing the loader uses.
   function automatic logic [7:0] chunk_field(input logic [15:0] word, input logic [1:0] idx);
      logic [7:0] res;
      res = 8'h00;
      case (idx)
         CHUNK_IDX0: res = {2'b00, word[CHUNK0_MSB:CHUNK0_LSB]};
         CHUNK_IDX1: res = {2'b00, word[CHUNK1_MSB:CHUNK1_LSB]};
         CHUNK_IDX2: res = {4'b0000, word[CHUNK2_MSB:CHUNK2_LSB]};
         default:    res = 8'h00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/instruction_dump_button_pulse.sv
// Synchronizes a raw push-button into the clk domain and emits a single-cycle
// pulse on each rising edge; a held button produces only one pulse.
module button_pulse #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         prev_q <= sync_q[SYNC_STAGES-1];
         pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/instruction_dump.sv
// Walks an address range of the instruction store and shows each word as three
// chunks, one per button press. Optional running XOR checksum: DUMP_CHECKSUM_EN.
module instruction_dump
   import instruction_dump_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] start_address,
   input  logic [ADDR_W-1:0] end_address,
   input  logic              step,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [15:0]       mem_data,
   output logic [7:0]        chunk_out,
   output logic [1:0]        chunk_idx,
   output logic [ADDR_W-1:0] word_addr,
   output logic              valid,
   output logic              done,
   output logic [15:0]       checksum
);

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] end_q;
   logic [15:0]       word_q;
   logic              step_pulse;

   button_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_step (
      .clk   (clk),
      .reset (reset),
      .raw   (step),
      .pulse (step_pulse)
   );

   assign mem_addr  = cur_addr;
   assign word_addr = cur_addr;

   // Presses outside SHOW0..SHOW2 simply fall through and are lost; load always wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cur_addr  <= '0;
         end_q     <= '0;
         word_q    <= '0;
         mem_rd_en <= 1'b0;
         chunk_out <= '0;
         chunk_idx <= '0;
         valid     <= 1'b0;
         done      <= 1'b0;
      end else begin
         mem_rd_en <= 1'b0;
         if (load) begin
            state     <= FETCH;
            cur_addr  <= start_address;
            end_q     <= end_address;
            mem_rd_en <= 1'b1;
            chunk_out <= '0;
            chunk_idx <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               FETCH: state <= WAIT;
               WAIT: begin
                  word_q    <= mem_data;
                  chunk_out <= chunk_field(mem_data, CHUNK_IDX0);
                  chunk_idx <= CHUNK_IDX0;
                  valid     <= 1'b1;
                  state     <= SHOW0;
               end
               SHOW0: if (step_pulse) begin
                  chunk_out <= chunk_field(word_q, CHUNK_IDX1);
                  chunk_idx <= CHUNK_IDX1;
                  state     <= SHOW1;
               end
               SHOW1: if (step_pulse) begin
                  chunk_out <= chunk_field(word_q, CHUNK_IDX2);
                  chunk_idx <= CHUNK_IDX2;
                  state     <= SHOW2;
               end
               SHOW2: if (step_pulse) begin
                  chunk_out <= '0;
                  chunk_idx <= '0;
                  valid     <= 1'b0;
                  if (cur_addr == end_q) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     cur_addr  <= cur_addr + 1'b1;
                     mem_rd_en <= 1'b1;
                     state     <= FETCH;
                  end
               end
               DONE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         checksum <= '0;
      end else if (load) begin
         checksum <= '0;
      end else if (state == WAIT) begin
         checksum <= checksum ^ mem_data;
      end
   end
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_dump.sv
// Randomized self-checking bench for instruction_dump against a range/word model;
// honours DUMP_CHECKSUM_EN when the design is built with it.
module tb_instruction_dump;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [5:0]  start_address;
   logic [5:0]  end_address;
   logic        step;
   logic [5:0]  mem_addr;
   logic        mem_rd_en;
   logic [15:0] mem_data;
   logic [7:0]  chunk_out;
   logic [1:0]  chunk_idx;
   logic [5:0]  word_addr;
   logic        valid;
   logic        done;
   logic [15:0] checksum;

   logic [15:0] mem [64];
   int          rd_log[$];
   int          checks = 0;
   int          errors = 0;

   instruction_dump #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .start_address (start_address),
      .end_address   (end_address),
      .step          (step),
      .mem_addr      (mem_addr),
      .mem_rd_en     (mem_rd_en),
      .mem_data      (mem_data),
      .chunk_out     (chunk_out),
      .chunk_idx     (chunk_idx),
      .word_addr     (word_addr),
      .valid         (valid),
      .done          (done),
      .checksum      (checksum)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction store; every read address is logged in order.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_data <= mem[mem_addr];
         rd_log.push_back(int'(mem_addr));
      end
   end

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int model_chunk(input int w, input int c);
      if (c == 0) return w / 1024;
      if (c == 1) return (w / 16) % 64;
      return w % 16;
   endfunction

   task automatic press_step();
      step = 1'b1;
      repeat ($urandom_range(4, 10)) @(negedge clk);
      step = 1'b0;
      repeat ($urandom_range(6, 10)) @(negedge clk);
   endtask

   task automatic do_load(input int s, input int e);
      @(negedge clk);
      start_address = 6'(s);
      end_address   = 6'(e);
      load          = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check_output("fetch_rd_en", mem_rd_en, 1);
      check_output("fetch_addr", mem_addr, s);
      check_output("fetch_valid", valid, 0);
      @(negedge clk);
      check_output("wait_rd_en", mem_rd_en, 0);
      @(negedge clk);
      check_output("show0_valid_latency", valid, 1);
   endtask

   task automatic dump_range(input int s, input int e);
      int n, base, a, w, cs;
      n    = (((e - s) % 64) + 64) % 64 + 1;
      base = rd_log.size();
      cs   = 0;
      do_load(s, e);
      for (int i = 0; i < n; i++) begin
         a  = (s + i) % 64;
         w  = int'(mem[a]);
         cs = cs ^ w;
         for (int c = 0; c < 3; c++) begin
            check_output("valid", valid, 1);
            check_output("word_addr", word_addr, a);
            check_output("chunk_idx", chunk_idx, c);
            check_output("chunk_out", chunk_out, model_chunk(w, c));
            press_step();
         end
      end
      check_output("done", done, 1);
      check_output("done_valid", valid, 0);
`ifdef DUMP_CHECKSUM_EN
      check_output("checksum", checksum, cs);
`else
      check_output("checksum", checksum, 0);
`endif
      check_output("read_count", rd_log.size() - base, n);
      for (int i = 0; i < n && base + i < rd_log.size(); i++)
         check_output("read_addr", rd_log[base + i], (s + i) % 64);
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s, e;
      reset = 1'b0;
      load  = 1'b0;
      step  = 1'b0;
      start_address = '0;
      end_address   = '0;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      repeat (3) @(negedge clk);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_rd_en", mem_rd_en, 0);
      check_output("rst_chunk_out", chunk_out, 0);
      check_output("rst_chunk_idx", chunk_idx, 0);
      check_output("rst_word_addr", word_addr, 0);
      check_output("rst_valid", valid, 0);
      check_output("rst_done", done, 0);
      check_output("rst_checksum", checksum, 0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check_output("idle_valid", valid, 0);

      $display("[TB] single word dump");
      mem[3] = 16'hA5C3;
      dump_range(3, 3);
      press_step();
      check_output("done_held", done, 1);

      $display("[TB] wrapping dump 62..1");
      mem[62] = 16'h0001;
      mem[63] = 16'h0002;
      mem[0]  = 16'h0003;
      mem[1]  = 16'h0004;
      dump_range(62, 1);

      $display("[TB] held button in SHOW0");
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      do_load(10, 12);
      step = 1'b1;
      repeat (50) @(negedge clk);
      check_output("held_idx", chunk_idx, 1);
      check_output("held_chunk", chunk_out, model_chunk(int'(mem[10]), 1));
      step = 1'b0;
      repeat (8) @(negedge clk);
      check_output("held_idx_after", chunk_idx, 1);

      $display("[TB] step glitch landing in FETCH");
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      step = 1'b0;
      start_address = 6'd20;
      end_address   = 6'd20;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check_output("glitch_rd_en", mem_rd_en, 1);
      check_output("glitch_addr", mem_addr, 20);
      repeat (2) @(negedge clk);
      check_output("glitch_valid", valid, 1);
      check_output("glitch_idx", chunk_idx, 0);
      repeat (10) @(negedge clk);
      check_output("glitch_idx_later", chunk_idx, 0);
      check_output("glitch_chunk", chunk_out, model_chunk(int'(mem[20]), 0));

      $display("[TB] load and step together in SHOW1");
      press_step();
      check_output("show1_idx", chunk_idx, 1);
      step = 1'b1;
      repeat (3) @(negedge clk);
      start_address = 6'd40;
      end_address   = 6'd41;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check_output("restart_rd_en", mem_rd_en, 1);
      check_output("restart_addr", mem_addr, 40);
      check_output("restart_valid", valid, 0);
      repeat (2) @(negedge clk);
      check_output("restart_show0_valid", valid, 1);
      check_output("restart_idx", chunk_idx, 0);
      check_output("restart_word_addr", word_addr, 40);
      step = 1'b0;
      repeat (8) @(negedge clk);
      check_output("restart_no_advance", chunk_idx, 0);

      $display("[TB] reset during SHOW2");
      do_load(5, 7);
      press_step();
      press_step();
      check_output("pre_rst_idx", chunk_idx, 2);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_output("mid_rst_mem_addr", mem_addr, 0);
      check_output("mid_rst_rd_en", mem_rd_en, 0);
      check_output("mid_rst_chunk_out", chunk_out, 0);
      check_output("mid_rst_chunk_idx", chunk_idx, 0);
      check_output("mid_rst_word_addr", word_addr, 0);
      check_output("mid_rst_valid", valid, 0);
      check_output("mid_rst_done", done, 0);
      check_output("mid_rst_checksum", checksum, 0);
      step = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check_output("post_rst_valid", valid, 0);
      check_output("post_rst_done", done, 0);
      check_output("post_rst_rd_en", mem_rd_en, 0);
      check_output("post_rst_addr", mem_addr, 0);
      step = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] full random dump 0..63");
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      dump_range(0, 63);

      $display("[TB] random short ranges");
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
         s = int'($urandom_range(0, 63));
         e = (s + int'($urandom_range(0, 5))) % 64;
         dump_range(s, e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
